// File: rtl/reg_load_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_load_arbiter                                           |
// | Description : Round-robin arbiter sharing one load-enabled register's    |
// |               write port; define ARB_FIXED_PRIO_EN for fixed priority.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reg_load_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     load,
  output logic [WIDTH-1:0]         reg_data,
  output logic [ID_W-1:0]          gnt_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               load_q, load_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0]   reg_data_q, reg_data_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;

  logic [ID_W-1:0]    win_idx;
  logic               win_vld;
  logic [WIDTH-1:0]   win_data;

`ifndef ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

  // Winner search: first set request at or above the start index, wrapping.
  always_comb begin : p_pick
    int cand;
    cand    = 0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = i;
`else
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
`endif
      if (!win_vld && req[ID_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = ID_W'(cand);
      end
    end
  end

  always_comb begin : p_data_mux
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == ID_W'(k)) begin
        win_data = req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : p_next
    state_d    = state_q;
    load_d     = 1'b0;
    ack_d      = '0;
    busy_d     = 1'b0;
    gnt_id_d   = gnt_id_q;
    reg_data_d = reg_data_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d    = S_GRANT;
          load_d     = 1'b1;
          busy_d     = 1'b1;
          gnt_id_d   = win_idx;
          reg_data_d = win_data;
        end
      end
      S_GRANT: begin
        // The register captured the byte at this edge, so ack lines up with data_out.
        state_d = S_ACK;
        busy_d  = 1'b1;
        ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_q;
      end
      S_ACK: begin
        state_d = S_IDLE;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_d = (gnt_id_q == ID_W'(NUM_REQ-1)) ? '0 : gnt_id_q + 1'b1;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_q     <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      reg_data_q <= '0;
      gnt_id_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      reg_data_q <= reg_data_d;
      gnt_id_q   <= gnt_id_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign load     = load_q;
  assign reg_data = reg_data_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reg_load_arbiter                                        |
// | Description : Scoreboard bench for reg_load_arbiter with a register model|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_reg_load_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        load;
  logic [7:0]  reg_data;
  logic [1:0]  gnt_id;
  logic        busy;

  reg_load_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .load     (load),
    .reg_data (reg_data),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard entries: {winner id, byte}
  logic [9:0] sb[$];
  logic [9:0] ent;
  logic       ack_pend  = 1'b0;
  logic [3:0] exp_ack   = '0;
  logic [7:0] exp_byte  = '0;
  logic [7:0] reg_model = '0;
  logic       rst_prev  = 1'b1;
  logic       load_prev = 1'b0;
  logic [7:0] data_prev = '0;
  logic       gap_chk   = 1'b0;
  logic       gap_first = 1'b0;
  int         cyc       = 0;
  int         last_load = 0;

  // Monitor: rst_prev/load_prev hold what the DUT sampled at the edge just passed.
  always @(negedge clk) begin
    cyc++;
    if (rst_prev) begin
      reg_model = '0;
      ack_pend  = 1'b0;
      check("rst_load", {31'd0, load}, 32'd0);
      check("rst_ack", {28'd0, ack}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_reg_data", {24'd0, reg_data}, 32'd0);
      check("rst_gnt_id", {30'd0, gnt_id}, 32'd0);
    end else begin
      if (load_prev) reg_model = data_prev;
      if (ack_pend) begin
        check("ack", {28'd0, ack}, {28'd0, exp_ack});
        check("data_out", {24'd0, reg_model}, {24'd0, exp_byte});
        ack_pend = 1'b0;
      end else begin
        check("ack_quiet", {28'd0, ack}, 32'd0);
      end
      check("ack_with_load", {31'd0, load && (ack != 4'd0)}, 32'd0);
      check("busy", {31'd0, busy}, {31'd0, load || (ack != 4'd0)});
      if (load) begin
        if (sb.size() == 0) begin
          check("unexpected_load", 32'd1, 32'd0);
        end else begin
          ent = sb.pop_front();
          check("gnt_id", {30'd0, gnt_id}, {30'd0, ent[9:8]});
          check("reg_data", {24'd0, reg_data}, {24'd0, ent[7:0]});
          exp_ack  = 4'b0001 << ent[9:8];
          exp_byte = ent[7:0];
          ack_pend = 1'b1;
          if (gap_chk && !gap_first) check("load_gap", cyc - last_load, 32'd3);
          gap_first = 1'b0;
          last_load = cyc;
        end
      end
    end
    rst_prev  = reset;
    load_prev = load;
    data_prev = reg_data;
  end

  initial begin
    // Reset held with all requests high
    reset    = 1'b1;
    req      = 4'b1111;
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    tick(2);
    reset = 1'b0;
    sb.push_back({2'd0, 8'h10});
    tick(3);
    req = 4'b0000;
    tick(2);

    // Single load from requester 2
    req_data[23:16] = 8'h81;
    req = 4'b0100;
    sb.push_back({2'd2, 8'h81});
    tick(3);
    req = 4'b0000;
    tick(2);
    req_data[23:16] = 8'h30;

    // Re-align the pointer to 0, then all requesters continuously
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    repeat (5) sb.push_back({2'd0, 8'h10});
`else
    sb.push_back({2'd0, 8'h10});
    sb.push_back({2'd1, 8'h20});
    sb.push_back({2'd2, 8'h30});
    sb.push_back({2'd3, 8'h40});
    sb.push_back({2'd0, 8'h10});
`endif
    gap_chk   = 1'b1;
    gap_first = 1'b1;
    req = 4'b1111;
    tick(14);
    req = 4'b0000;
    gap_chk = 1'b0;
    tick(3);

    // Late arrival: requester 1 raises during requester 3's grant
    req = 4'b1000;
    sb.push_back({2'd3, 8'h40});
    gap_chk   = 1'b1;
    gap_first = 1'b1;
    tick(1);
    req = 4'b1010;
    sb.push_back({2'd1, 8'h20});
    tick(2);
    req = 4'b0010;
    tick(3);
    req = 4'b0000;
    gap_chk = 1'b0;
    tick(2);

    // Reset during requester 0's grant
    req = 4'b0001;
    sb.push_back({2'd0, 8'h10});
    tick(1);
    reset = 1'b1;
    req   = 4'b0000;
    tick(1);
    reset = 1'b0;
    req   = 4'b0110;
    sb.push_back({2'd1, 8'h20});
    tick(3);
    req = 4'b0000;
    tick(2);
    req = 4'b0001;
    sb.push_back({2'd0, 8'h10});
    tick(3);
    req = 4'b0000;
    tick(1);

    // Idle hold
    tick(20);
    check("idle_reg_data", {24'd0, reg_data}, 32'h10);
    check("idle_gnt_id", {30'd0, gnt_id}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);
    check("ack_outstanding", {31'd0, ack_pend}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Shares the write port of one 8-bit load-enabled register (`clk`, `reset`, `load`, `data_in` → `data_out`) between several requesters. Each requester posts a request with its byte. The arbiter picks one winner round-robin and drives the register's `load`/`data_in` for exactly one cycle. It then acknowledges the winner once the register holds the new value. The block sits directly in front of the register; the register's `data_out` is not consumed here.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8
- `WIDTH`, 8 — data width; matches the register width
- `clk` input 1 — single clock; all state updates on rising edge
- `reset` input 1 — synchronous, active-high; sampled on rising edge of `clk`
- `req` input NUM_REQ — request per requester; bit k belongs to requester k
- `req_data` input NUM_REQ*WIDTH — flattened data; requester k at bits [k*WIDTH +: WIDTH]
- `ack` output NUM_REQ — one-cycle acknowledge to the served requester
- `load` output 1 — to the register's `load`
- `reg_data` output WIDTH — to the register's `data_in`
- `gnt_id` output clog2(NUM_REQ) — index of the current or last winner
- `busy` output 1 — high in GRANT and ACK

## Operation
- FSM states and transitions:
  - IDLE → GRANT when any `req` bit is high.
  - GRANT → ACK unconditionally.
  - ACK → IDLE unconditionally.
- IDLE:
  - `load`=0, `ack`=0.
  - Arbitration happens on the IDLE→GRANT edge. Winner = first set `req` bit searching upward from `rr_ptr`, wrapping from NUM_REQ-1 to 0.
  - The winner index is registered into `gnt_id`.
  - `req_data` of the winner is registered into `reg_data`.
- GRANT:
  - `load`=1 for exactly one cycle.
  - `reg_data` holds the winner's byte.
  - Requests arriving or dropping during GRANT do not change the winner.
- ACK:
  - `load`=0 and `ack[gnt_id]`=1 for exactly one cycle.
  - `rr_ptr` ← (`gnt_id`+1) mod NUM_REQ on the ACK→IDLE edge.
- Requester rule: hold `req` and data stable until `ack` is seen, then deassert `req` on that same clock edge. A `req` still high in IDLE is a new request.
- `reg_data` and `gnt_id` retain their last value outside GRANT. Only the `load` qualifier is meaningful.
- At most one `ack` bit is ever high. `ack` is never high while `load` is high.
- Reset values:
  - State = IDLE.
  - `load`=0, `ack`=0, `busy`=0.
  - `reg_data`=0, `gnt_id`=0.
  - `rr_ptr`=0, so requester 0 has highest priority after reset.

## Timing
- Request sampled high at edge E0 (IDLE): `load`=1 in cycle E0–E1.
- The register captures at E1. `ack` is high in cycle E1–E2, and the register's `data_out` already equals the byte during that cycle.
- IDLE again after E2. Request-to-ack latency is 2 cycles. Peak throughput is one load per 3 cycles.
- All requesters asserting continuously: grants rotate 0,1,2,3,0,… with no requester starved. Worst-case wait = NUM_REQ×3 cycles.
- Single requester asserting continuously, following the requester rule: served every 3 cycles.
- `req`=0 in IDLE: stays IDLE, no outputs change.
- Reset mid-operation:
  - Reset in GRANT: `load` drops at the next edge and no `ack` is issued for that transaction. The register is cleared by the same reset.
  - Reset in ACK: `ack` drops at the next edge and `rr_ptr` returns to 0.
  - Requesters must re-request after reset.
- Reset has priority over every transition.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: fixed priority.
  - Lowest-index set `req` wins.
  - `rr_ptr` is not implemented and never updates.
  - Starvation of high indices is permitted.
- `ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.
- The FSM, latency and handshake are identical in both builds.

## Test plan
- Reset: assert `reset` for 2 cycles with `req`=4'b1111 → `load`=0, `ack`=0, `busy`=0, `reg_data`=8'h00, `gnt_id`=0 throughout; first grant after release goes to requester 0.
- Single load: `req`=4'b0100, requester 2 data 8'h81 → `load`=1 with `reg_data`=8'h81 one cycle later; `ack`=4'b0100 the next cycle; register `data_out`=8'h81; `gnt_id`=2.
- Round-robin: `req`=4'b1111 held per requester rule, data 8'h10/8'h20/8'h30/8'h40 → loads in order 8'h10, 8'h20, 8'h30, 8'h40, 8'h10, spaced 3 cycles apart. With `ARB_FIXED_PRIO_EN`, the order instead stays 8'h10 as long as requester 0 requests.
- Late arrival: requester 1 raises `req` during requester 3's GRANT → requester 3 is served unchanged; requester 1 is granted in the first IDLE after requester 3's ACK.
- Reset mid-grant: assert `reset` during GRANT for requester 0 → no `ack`, `load`=0 next cycle, `rr_ptr`=0; after release with `req`=4'b0001 the full 3-cycle transaction completes.
- Idle hold: `req`=0 for 20 cycles → `busy`, `load` and `ack` remain 0; `reg_data` is unchanged.
